// File: rtl/dec_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dec_scan_pkg
// Purpose  : Shared types and constants for the decimal scan display:
//            conversion FSM states, segment codes and the BCD add-3 helper.
// Revision : 1.0 - initial release
// ============================================================================
package dec_scan_pkg;

  // Number of multiplexed digit positions on the board.
  localparam int NUM_DIGITS = 8;

  // Active-low segment patterns {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // Binary-to-BCD conversion sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV_A = 2'd1,
    ST_CONV_B = 2'd2,
    ST_COMMIT = 2'd3
  } conv_state_t;

  // Shift-add-3 correction: any BCD nibble of 5 or more gets 3 added so the
  // following left shift carries correctly into the next decade.
  function automatic logic [11:0] bcd_add3(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    for (int n = 0; n < 3; n++) begin
      if (v[4*n +: 4] >= 4'd5) begin
        r[4*n +: 4] = v[4*n +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Purpose  : Combinational BCD digit to active-low seven-segment decoder
//            with a blank override. Non-decimal codes display blank.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
  import dec_scan_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Map one decimal digit onto its segment pattern, or blank it.
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_bcd)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dec_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : dec_scan_display
// Purpose  : Converts two result bytes to 3-digit decimal with a sequential
//            shift-add-3 engine and scans them onto an 8-digit active-low
//            seven-segment display. Layout: [blank A100 A10 A1 blank B100
//            B10 B1], digit 0 rightmost.
// Revision : 1.0 - initial release
// ============================================================================
module dec_scan_display
  import dec_scan_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [7:0]            NumberA,
  input  logic [7:0]            NumberB,
  output logic [NUM_DIGITS-1:0] en_out,
  output logic [6:0]            out7,
  output logic                  busy
);

  localparam int                 c_cnt_w  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
  localparam int                 c_idx_w  = $clog2(NUM_DIGITS);

  // Conversion sequencer
  conv_state_t r_state;
  conv_state_t w_state_nxt;

  logic [7:0]  r_snap_a;
  logic [7:0]  r_snap_b;
  logic [7:0]  r_shift;
  logic [11:0] r_bcd;
  logic [11:0] r_res_a;
  logic [11:0] r_disp_a;
  logic [11:0] r_disp_b;
  logic [2:0]  r_bit;
  logic        r_busy;

  logic        w_start;
  logic        w_last_bit;
  logic [11:0] w_bcd_adj;
  logic [11:0] w_bcd_nxt;
  logic [7:0]  w_shift_nxt;

  // Scan side
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_idx_w-1:0] r_idx;
  logic [11:0]        w_val;
  logic [3:0]         w_dig;
  logic               w_blank;
  logic [6:0]         w_seg;

  assign w_start    = (r_state == ST_IDLE) &&
                      ((NumberA != r_snap_a) || (NumberB != r_snap_b));
  assign w_last_bit = (r_bit == 3'd7);
  assign w_bcd_adj  = bcd_add3(r_bcd);
  assign busy       = r_busy;

  // One shift-add-3 step: correct the BCD nibbles, then shift the operand
  // MSB into the BCD LSB.
  always_comb begin
    {w_bcd_nxt, w_shift_nxt} = {w_bcd_adj, r_shift} << 1;
  end

  // Conversion FSM state register.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Conversion FSM next-state: A for 8 steps, B for 8 steps, then commit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start)    w_state_nxt = ST_CONV_A;
      ST_CONV_A: if (w_last_bit) w_state_nxt = ST_CONV_B;
      ST_CONV_B: if (w_last_bit) w_state_nxt = ST_COMMIT;
      ST_COMMIT:                 w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  // Conversion datapath: snapshot inputs, run both conversions, and publish
  // both results together so the display never shows a half-updated pair.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_snap_a <= '0;
      r_snap_b <= '0;
      r_shift  <= '0;
      r_bcd    <= '0;
      r_res_a  <= '0;
      r_disp_a <= '0;
      r_disp_b <= '0;
      r_bit    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_snap_a <= NumberA;
            r_snap_b <= NumberB;
            r_shift  <= NumberA;
            r_bcd    <= '0;
            r_bit    <= '0;
          end
        end
        ST_CONV_A: begin
          r_bit <= r_bit + 3'd1;
          if (w_last_bit) begin
            r_res_a <= w_bcd_nxt;
            r_shift <= r_snap_b;
            r_bcd   <= '0;
          end else begin
            r_bcd   <= w_bcd_nxt;
            r_shift <= w_shift_nxt;
          end
        end
        ST_CONV_B: begin
          r_bit   <= r_bit + 3'd1;
          r_bcd   <= w_bcd_nxt;
          r_shift <= w_shift_nxt;
        end
        ST_COMMIT: begin
          r_disp_a <= r_res_a;
          r_disp_b <= r_bcd;
        end
        default: ;
      endcase
    end
  end

  // Busy covers the whole conversion and drops on the edge where the new
  // digits first reach out7.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= w_start || (r_state != ST_IDLE);
    end
  end

  // Free-running refresh divider and digit index, independent of conversion.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == c_cnt_last) begin
      r_cnt <= '0;
      r_idx <= r_idx + c_idx_w'(1);
    end else begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  // Select the digit for the current index, with optional leading-zero blanking.
  always_comb begin
    w_val   = r_idx[2] ? r_disp_a : r_disp_b;
    w_dig   = 4'd0;
    w_blank = 1'b1;
    case (r_idx[1:0])
      2'd0: begin
        w_dig   = w_val[3:0];
        w_blank = 1'b0;
      end
      2'd1: begin
        w_dig   = w_val[7:4];
        w_blank = BLANK_LEADING && (w_val[11:4] == 8'd0);
      end
      2'd2: begin
        w_dig   = w_val[11:8];
        w_blank = BLANK_LEADING && (w_val[11:8] == 4'd0);
      end
      default: begin
        w_dig   = 4'd0;
        w_blank = 1'b1;
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .i_bcd   (w_dig),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );

  // Register anode and segment drive together so they change on the same edge.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      en_out <= '1;
      out7   <= SEG_BLANK;
    end else begin
      en_out <= ~(NUM_DIGITS'(1) << r_idx);
      out7   <= w_seg;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dec_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_scan_display
// Purpose  : Self-checking bench for dec_scan_display. Three instances share
//            the inputs: refresh 4 with blanking, refresh 4 without blanking,
//            refresh 2 with blanking. A cycle-level decimal model predicts
//            every output of every instance on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dec_scan_display;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_in;
  logic [7:0] b_in;

  logic [7:0] en4, en4nb, en2;
  logic [6:0] seg4, seg4nb, seg2;
  logic       busy4, busy4nb, busy2;

  int n_cmp;
  int n_bad;

  // Model state
  int         m_snap_a, m_snap_b, m_disp_a, m_disp_b, m_timer, m_cyc;
  logic [7:0] e_en4, e_en2;
  logic [6:0] e_seg4, e_seg4nb, e_seg2;
  logic       e_busy;

  dec_scan_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u_dut4 (
    .Clk(clk), .Reset(rst_n), .NumberA(a_in), .NumberB(b_in),
    .en_out(en4), .out7(seg4), .busy(busy4));

  dec_scan_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u_dut4_nb (
    .Clk(clk), .Reset(rst_n), .NumberA(a_in), .NumberB(b_in),
    .en_out(en4nb), .out7(seg4nb), .busy(busy4nb));

  dec_scan_display #(.REFRESH_DIV(2), .BLANK_LEADING(1'b1)) u_dut2 (
    .Clk(clk), .Reset(rst_n), .NumberA(a_in), .NumberB(b_in),
    .en_out(en2), .out7(seg2), .busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected segments for a digit position, from the displayed decimal values.
  function automatic logic [6:0] seg_of(input int idx, input int a, input int b, input bit bl);
    int v, h, t, o;
    if (idx == 3 || idx == 7) return 7'h7F;
    v = (idx < 4) ? b : a;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    case (idx % 4)
      0: return digit_seg(o);
      1: return (bl && h == 0 && t == 0) ? 7'h7F : digit_seg(t);
      default: return (bl && h == 0) ? 7'h7F : digit_seg(h);
    endcase
  endfunction

  // Advance the model by one rising edge using the values held before it.
  task automatic model_step();
    int  i4, i2;
    bit  start;
    if (!rst_n) begin
      m_snap_a = 0; m_snap_b = 0; m_disp_a = 0; m_disp_b = 0;
      m_timer = 0; m_cyc = 0;
      e_en4 = 8'hFF; e_en2 = 8'hFF;
      e_seg4 = 7'h7F; e_seg4nb = 7'h7F; e_seg2 = 7'h7F;
      e_busy = 1'b0;
    end else begin
      i4 = (m_cyc / 4) % 8;
      i2 = (m_cyc / 2) % 8;
      e_en4    = ~(8'd1 << i4);
      e_en2    = ~(8'd1 << i2);
      e_seg4   = seg_of(i4, m_disp_a, m_disp_b, 1'b1);
      e_seg4nb = seg_of(i4, m_disp_a, m_disp_b, 1'b0);
      e_seg2   = seg_of(i2, m_disp_a, m_disp_b, 1'b1);
      start  = (m_timer == 0) && ((int'(a_in) != m_snap_a) || (int'(b_in) != m_snap_b));
      e_busy = start || (m_timer != 0);
      m_cyc++;
      if (start) begin
        m_snap_a = int'(a_in);
        m_snap_b = int'(b_in);
        m_timer  = 17;
      end else if (m_timer != 0) begin
        m_timer--;
        if (m_timer == 0) begin
          m_disp_a = m_snap_a;
          m_disp_b = m_snap_b;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("d4.en_out",   en4,    e_en4);
    check("d4.out7",     seg4,   e_seg4);
    check("d4.busy",     busy4,  e_busy);
    check("d4nb.en_out", en4nb,  e_en4);
    check("d4nb.out7",   seg4nb, e_seg4nb);
    check("d4nb.busy",   busy4nb, e_busy);
    check("d2.en_out",   en2,    e_en2);
    check("d2.out7",     seg2,   e_seg2);
    check("d2.busy",     busy2,  e_busy);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy4 && guard < 60) begin
      tick();
      guard++;
    end
    check("idle_timeout", busy4, 1'b0);
  endtask

  initial begin
    int len;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    a_in  = 8'd0;
    b_in  = 8'd0;

    // Reset held low for five cycles
    run(5);
    check("rst.en_out", en4, 8'hFF);
    check("rst.out7",   seg4, 7'h7F);
    check("rst.busy",   busy4, 1'b0);

    // First active cycle shows digit 0 as a zero
    rst_n = 1'b1;
    tick();
    check("first.en_out", en4, 8'hFE);
    check("first.out7",   seg4, 7'h40);

    // Static inputs: two full scans of the anode pattern
    run(70);

    // A=255, B=0: busy length and digit contents
    a_in = 8'd255;
    b_in = 8'd0;
    len = 0;
    tick();
    while (busy4 && len < 40) begin
      len++;
      tick();
    end
    check("busy_len", len, 18);
    run(34);

    // A=7, B=100: leading-zero blanking on both instances
    a_in = 8'd7;
    b_in = 8'd100;
    run(20);
    run(34);

    // A changes from 12 to 34 at cycle 3 of CONV_A
    a_in = 8'd12;
    run(4);
    a_in = 8'd34;
    run(40);
    wait_idle();
    run(34);

    // Reset during CONV_B of A=200
    a_in = 8'd200;
    run(12);
    rst_n = 1'b0;
    tick();
    check("midrst.en_out", en4, 8'hFF);
    check("midrst.out7",   seg4, 7'h7F);
    check("midrst.busy",   busy4, 1'b0);
    rst_n = 1'b1;
    run(54);

    // Randomized inputs, including changes in the middle of conversions
    for (int it = 0; it < 40; it++) begin
      a_in = 8'($urandom_range(0, 255));
      b_in = 8'($urandom_range(0, 255));
      run(int'($urandom_range(3, 45)));
    end
    a_in = 8'($urandom_range(0, 255));
    b_in = 8'($urandom_range(0, 255));
    wait_idle();
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
